// File: rtl/lock_pkg.sv
// Shared types and constants for the door-lock controller: state encoding,
// PIN geometry and helpers for sizing the shared countdown timer.
package lock_pkg;

    localparam int PIN_W = 16;
    localparam logic [PIN_W-1:0] PIN_DEFAULT = 16'h1234;

    typedef enum logic [2:0] {
        LOCKED,
        UNLOCKED,
        DOOR_OPEN,
        LOCKOUT,
        SETUP
    } lock_state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A one-cycle window still needs a 1-bit counter.
    function automatic int timer_width(input int max_ms);
        return (max_ms > 1) ? $clog2(max_ms) : 1;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by every timed state of the lock FSM.
// Saturates at zero; expired is high whenever the count is zero.
module lock_timer #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking '<=' so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/lock_access_controller.sv
// Door-lock sequencing FSM: PIN check, bolt window, fail lockout and PIN change.
// Define DOOR_ALARM_EN to add the door-held-open alarm; otherwise alarm is tied low.
module lock_access_controller
    import lock_pkg::*;
#(
    parameter int MAX_FAILS  = 3,
    parameter int UNLOCK_MS  = 5000,
    parameter int LOCKOUT_MS = 10000,
    parameter int SETUP_MS   = 10000,
    parameter int ALARM_MS   = 10000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pin_valid,
    input  logic [PIN_W-1:0]               pin_code,
    input  logic                           door_closed,
    input  logic                           hold_long,
    output logic                           unlock,
    output logic                           lockout,
    output logic                           setup_mode,
    output logic                           alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int MAX_MS = max_of(max_of(UNLOCK_MS, LOCKOUT_MS), max_of(SETUP_MS, ALARM_MS));
    localparam int TW     = timer_width(MAX_MS);
    localparam int FW     = $clog2(MAX_FAILS + 1);

    lock_state_t      state_q, state_d;
    logic [FW-1:0]    fail_q, fail_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic             hold_q;
    logic             unlock_q, lockout_q, setup_q;
    logic             hold_rise;
    logic             load;
    logic [TW-1:0]    load_val;
    logic             expired;

    assign hold_rise = hold_long & ~hold_q;

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        pin_d    = pin_q;
        load     = 1'b0;
        load_val = '0;

        case (state_q)
            LOCKED: begin
                if (pin_valid) begin
                    if (pin_code == pin_q) begin
                        state_d = UNLOCKED;
                        fail_d  = '0;
                    end else if (fail_q == FW'(MAX_FAILS - 1)) begin
                        state_d = LOCKOUT;
                        fail_d  = FW'(MAX_FAILS);
                    end else begin
                        fail_d = fail_q + FW'(1);
                    end
                end
            end
            UNLOCKED: begin
                if (!door_closed) begin
                    state_d = DOOR_OPEN;
                end else if (hold_rise) begin
                    state_d = SETUP;
                end else if (expired) begin
                    state_d = LOCKED;
                end
            end
            DOOR_OPEN: begin
                if (door_closed) begin
                    state_d = LOCKED;
                end
            end
            LOCKOUT: begin
                if (expired) begin
                    state_d = LOCKED;
                    fail_d  = '0;
                end
            end
            SETUP: begin
                // A submitted PIN takes precedence over an expiring window.
                if (pin_valid) begin
                    pin_d   = pin_code;
                    state_d = LOCKED;
                end else if (expired) begin
                    state_d = LOCKED;
                end
            end
            default: state_d = LOCKED;
        endcase

        if (state_d != state_q) begin
            load = 1'b1;
            case (state_d)
                UNLOCKED: load_val = TW'(UNLOCK_MS - 1);
                LOCKOUT:  load_val = TW'(LOCKOUT_MS - 1);
                SETUP:    load_val = TW'(SETUP_MS - 1);
`ifdef DOOR_ALARM_EN
                DOOR_OPEN: load_val = TW'(ALARM_MS - 1);
`endif
                default:  load_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOCKED;
            fail_q    <= '0;
            pin_q     <= PIN_DEFAULT;
            hold_q    <= 1'b0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
            setup_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fail_q    <= fail_d;
            pin_q     <= pin_d;
            hold_q    <= hold_long;
            unlock_q  <= (state_d == UNLOCKED) || (state_d == DOOR_OPEN);
            lockout_q <= (state_d == LOCKOUT);
            setup_q   <= (state_d == SETUP);
        end
    end

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    assign unlock     = unlock_q;
    assign lockout    = lockout_q;
    assign setup_mode = setup_q;
    assign fail_count = fail_q;

`ifdef DOOR_ALARM_EN
    // The timer holds at zero, so the alarm stays up until the door closes.
    assign alarm = (state_q == DOOR_OPEN) && expired;
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed scoreboard bench for lock_access_controller with short timing windows.
module tb_lock_access_controller;

    typedef struct packed {
        logic       unlock;
        logic       lockout;
        logic       setup_mode;
        logic       alarm;
        logic [1:0] fail;
    } obs_t;

`ifdef DOOR_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pin_valid;
    logic [15:0] pin_code;
    logic        door_closed;
    logic        hold_long;
    logic        unlock, lockout, setup_mode, alarm;
    logic [1:0]  fail_count;

    int errors = 0;
    int checks = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    lock_access_controller #(
        .MAX_FAILS  (3),
        .UNLOCK_MS  (8),
        .LOCKOUT_MS (12),
        .SETUP_MS   (10),
        .ALARM_MS   (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pin_valid   (pin_valid),
        .pin_code    (pin_code),
        .door_closed (door_closed),
        .hold_long   (hold_long),
        .unlock      (unlock),
        .lockout     (lockout),
        .setup_mode  (setup_mode),
        .alarm       (alarm),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Push the expected post-edge outputs, clock once, then pop and compare.
    task automatic step(input logic pv, input logic [15:0] code, input string tag,
                        input logic u, input logic lo, input logic su, input logic al,
                        input logic [1:0] fc);
        obs_t  e;
        string t;
        pin_valid = pv;
        pin_code  = code;
        exp_q.push_back('{unlock: u, lockout: lo, setup_mode: su, alarm: al, fail: fc});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        pin_valid = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".unlock"},  {1'b0, unlock},     {1'b0, e.unlock});
        check({t, ".lockout"}, {1'b0, lockout},    {1'b0, e.lockout});
        check({t, ".setup"},   {1'b0, setup_mode}, {1'b0, e.setup_mode});
        check({t, ".alarm"},   {1'b0, alarm},      {1'b0, e.alarm});
        check({t, ".fail"},    fail_count,         e.fail);
    endtask

    initial begin
        reset       = 1'b1;
        pin_valid   = 1'b0;
        pin_code    = 16'h0000;
        door_closed = 1'b1;
        hold_long   = 1'b0;
        #2;
        step(1'b0, 16'h0000, "rst0", 0, 0, 0, 0, 2'd0);
        step(1'b1, 16'h1234, "rst1", 0, 0, 0, 0, 2'd0);
        reset = 1'b0;

        // Correct PIN opens the bolt for exactly 8 cycles.
        step(1'b1, 16'h1234, "t1_open", 1, 0, 0, 0, 2'd0);
        for (int i = 1; i < 8; i++) step(1'b0, 16'h0, $sformatf("t1_hold%0d", i), 1, 0, 0, 0, 2'd0);
        step(1'b0, 16'h0, "t1_relock", 0, 0, 0, 0, 2'd0);

        // Three misses trigger a 12-cycle lockout that ignores PIN entry.
        step(1'b1, 16'h0000, "t2_miss1", 0, 0, 0, 0, 2'd1);
        step(1'b1, 16'h0000, "t2_miss2", 0, 0, 0, 0, 2'd2);
        step(1'b1, 16'h0000, "t2_miss3", 0, 1, 0, 0, 2'd3);
        step(1'b1, 16'h1234, "t2_goodign", 0, 1, 0, 0, 2'd3);
        step(1'b1, 16'h0000, "t2_badign", 0, 1, 0, 0, 2'd3);
        for (int i = 3; i < 12; i++) step(1'b0, 16'h0, $sformatf("t2_lo%0d", i), 0, 1, 0, 0, 2'd3);
        step(1'b0, 16'h0, "t2_end", 0, 0, 0, 0, 2'd0);

        // A success clears partial failures.
        step(1'b1, 16'h0001, "t3_miss1", 0, 0, 0, 0, 2'd1);
        step(1'b1, 16'h0002, "t3_miss2", 0, 0, 0, 0, 2'd2);
        step(1'b1, 16'h1234, "t3_open", 1, 0, 0, 0, 2'd0);
        for (int i = 1; i < 8; i++) step(1'b0, 16'h0, $sformatf("t3_hold%0d", i), 1, 0, 0, 0, 2'd0);
        step(1'b0, 16'h0, "t3_relock", 0, 0, 0, 0, 2'd0);
        step(1'b1, 16'h9999, "t3_miss", 0, 0, 0, 0, 2'd1);

        // Door opened at cycle 3 keeps the bolt retracted past the window.
        step(1'b1, 16'h1234, "t4_open", 1, 0, 0, 0, 2'd0);
        step(1'b0, 16'h0, "t4_c2", 1, 0, 0, 0, 2'd0);
        step(1'b0, 16'h0, "t4_c3", 1, 0, 0, 0, 2'd0);
        door_closed = 1'b0;
        step(1'b0, 16'h0, "t4_dopen1", 1, 0, 0, 0, 2'd0);
        for (int k = 2; k <= 11; k++)
            step(1'b1, 16'h0000, $sformatf("t4_dopen%0d", k), 1, 0, 0, ALARM_ON && (k >= 6), 2'd0);
        door_closed = 1'b1;
        step(1'b0, 16'h0, "t4_close", 0, 0, 0, 0, 2'd0);

        // Long hold during a session enters setup; new PIN replaces the default.
        step(1'b1, 16'h1234, "t5_open", 1, 0, 0, 0, 2'd0);
        step(1'b0, 16'h0, "t5_c2", 1, 0, 0, 0, 2'd0);
        hold_long = 1'b1;
        step(1'b0, 16'h0, "t5_setup", 0, 0, 1, 0, 2'd0);
        step(1'b1, 16'h4321, "t5_newpin", 0, 0, 0, 0, 2'd0);
        step(1'b1, 16'h1234, "t5_oldpin", 0, 0, 0, 0, 2'd1);
        step(1'b1, 16'h4321, "t5_open2", 1, 0, 0, 0, 2'd0);
        for (int i = 1; i < 8; i++) step(1'b0, 16'h0, $sformatf("t5_heldhi%0d", i), 1, 0, 0, 0, 2'd0);
        step(1'b0, 16'h0, "t5_relock", 0, 0, 0, 0, 2'd0);
        hold_long = 1'b0;
        step(1'b0, 16'h0, "t5_idle", 0, 0, 0, 0, 2'd0);

        // PIN entry on the setup expiry cycle still stores the new PIN.
        step(1'b1, 16'h4321, "t6_open", 1, 0, 0, 0, 2'd0);
        hold_long = 1'b1;
        step(1'b0, 16'h0, "t6_setup", 0, 0, 1, 0, 2'd0);
        hold_long = 1'b0;
        for (int i = 1; i <= 9; i++) step(1'b0, 16'h0, $sformatf("t6_wait%0d", i), 0, 0, 1, 0, 2'd0);
        step(1'b1, 16'h5555, "t6_expiry_pin", 0, 0, 0, 0, 2'd0);
        step(1'b1, 16'h1234, "t6_oldpin", 0, 0, 0, 0, 2'd1);
        step(1'b1, 16'h5555, "t6_open2", 1, 0, 0, 0, 2'd0);
        step(1'b0, 16'h0, "t6_c2", 1, 0, 0, 0, 2'd0);

        // Reset mid-session drops all outputs and restores the default PIN.
        reset = 1'b1;
        step(1'b0, 16'h0, "t6_reset", 0, 0, 0, 0, 2'd0);
        reset = 1'b0;
        step(1'b1, 16'h5555, "t6_revert_miss", 0, 0, 0, 0, 2'd1);
        step(1'b1, 16'h1234, "t6_default_open", 1, 0, 0, 0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
